keypad_time_encoder: RTL

- Converts raw microwave keypad digit presses (0-9) into the 3-digit BCD cook time (M:SS) consumed by the timer and 7-segment display path. It is the input-side counterpart of the BCD-to-segment display decoder.
- Per key press it:
  - synchronizes and debounces the lines,
  - priority-checks the press and encodes it to BCD,
  - shifts the digit into a right-entry register, microwave style (typed digits enter at units, older digits move left).

---
 rtl/microwave_pkg.sv | 46 ++++
 rtl/keypad_time_encoder_if.sv | 26 ++
 rtl/key_debouncer.sv | 91 +++++++++
 rtl/keypad_time_encoder.sv | 108 ++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared constants, types and helpers for the microwave keypad entry path.
package microwave_pkg;

   localparam int unsigned BCD_W    = 4;
   localparam int unsigned NUM_KEYS = 10;

   localparam logic [BCD_W-1:0] MAX_SEC_TENS        = 4'd5;
   localparam logic [15:0]      DEF_DEBOUNCE_CYCLES = 16'd50000;
   localparam logic [15:0]      DEF_BEEP_CYCLES     = 16'd25000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      HELD      = 2'd2,
      DEB_REL   = 2'd3
   } deb_state_e;

   typedef logic [NUM_KEYS-1:0] key_vec_t;

   typedef struct packed {
      logic [BCD_W-1:0] minutos;
      logic [BCD_W-1:0] sec_dezenas;
      logic [BCD_W-1:0] sec_unidades;
   } cook_time_t;

   // True when exactly one key line is set.
   function automatic logic is_one_hot(input key_vec_t v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
         n = n + 4'(v[i]);
      end
      return (n == 4'd1);
   endfunction

   // Index of the set key line as a BCD digit; meaningful only for one-hot input.
   function automatic logic [BCD_W-1:0] key_to_bcd(input key_vec_t v);
      logic [BCD_W-1:0] d;
      d = '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
         if (v[i]) d = BCD_W'(i);
      end
      return d;
   endfunction

endpackage

// File: rtl/keypad_time_encoder_if.sv
// Keypad-to-timer bundle: raw key/control inputs and the BCD cook time outputs.
interface keypad_time_encoder_if;
   import microwave_pkg::*;

   key_vec_t         keys;
   logic             entry_en;
   logic             clear;
   logic [BCD_W-1:0] sec_unidades;
   logic [BCD_W-1:0] sec_dezenas;
   logic [BCD_W-1:0] minutos;
   logic             digit_stb;
   logic             key_err;
   logic             time_nonzero;
   logic             beep;

   modport master (
      output keys, entry_en, clear,
      input  sec_unidades, sec_dezenas, minutos, digit_stb, key_err, time_nonzero, beep
   );

   modport slave (
      input  keys, entry_en, clear,
      output sec_unidades, sec_dezenas, minutos, digit_stb, key_err, time_nonzero, beep
   );

endinterface

// File: rtl/key_debouncer.sv
// Synchronizes raw key lines and debounces press/release; emits one press_evt_c per stable press.
module key_debouncer
   import microwave_pkg::*;
#(
   parameter logic [15:0]  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned  CNT_W           = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   input  key_vec_t keys,
   output key_vec_t snap,
   output logic     press_evt_c
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

   key_vec_t         keys_m;
   key_vec_t         keys_s;
   key_vec_t         snap_nxt;
   deb_state_e       state;
   deb_state_e       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Two-flop synchronizer for the asynchronous key lines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keys_m <= '0;
         keys_s <= '0;
      end else begin
         keys_m <= keys;
         keys_s <= keys_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         snap  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         snap  <= snap_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Press is reported on the DEB_PRESS->HELD edge only, so each press evaluates once.
   always_comb begin
      state_nxt   = state;
      snap_nxt    = snap;
      cnt_nxt     = cnt;
      press_evt_c = 1'b0;
      case (state)
         IDLE: begin
            if (keys_s != '0) begin
               snap_nxt  = keys_s;
               cnt_nxt   = '0;
               state_nxt = DEB_PRESS;
            end
         end
         DEB_PRESS: begin
            if (keys_s != snap) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt   = HELD;
               press_evt_c = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (keys_s == '0) begin
               cnt_nxt   = '0;
               state_nxt = DEB_REL;
            end
         end
         DEB_REL: begin
            if (keys_s != '0) begin
               state_nxt = HELD;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/keypad_time_encoder.sv
// Keypad digit entry into a right-shifting M:SS BCD cook time register.
// Optional beep driver enabled by defining KEYPAD_BEEP_EN.
module keypad_time_encoder
   import microwave_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = 16,
   parameter logic [15:0] BEEP_CYCLES     = DEF_BEEP_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   keypad_time_encoder_if.slave  bus
);

   key_vec_t   snap;
   logic       press_evt_c;
   cook_time_t digits;
   cook_time_t digits_nxt;
   logic       digit_stb;
   logic       stb_nxt;
   logic       key_err;
   logic       err_nxt;

   key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_key_debouncer (
      .clk         (clk),
      .rst_n       (rst_n),
      .keys        (bus.keys),
      .snap        (snap),
      .press_evt_c (press_evt_c)
   );

   // Press evaluation; clear wins over a same-cycle shift and suppresses its strobe.
   always_comb begin
      digits_nxt = digits;
      stb_nxt    = 1'b0;
      err_nxt    = 1'b0;
      if (press_evt_c) begin
         if (!is_one_hot(snap)) begin
            err_nxt = 1'b1;
         end else if (bus.entry_en) begin
            if ((digits.minutos != '0) || (digits.sec_unidades > MAX_SEC_TENS)) begin
               err_nxt = 1'b1;
            end else begin
               digits_nxt.minutos      = digits.sec_dezenas;
               digits_nxt.sec_dezenas  = digits.sec_unidades;
               digits_nxt.sec_unidades = key_to_bcd(snap);
               stb_nxt                 = 1'b1;
            end
         end
      end
      if (bus.clear) begin
         digits_nxt = '0;
         stb_nxt    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits    <= '0;
         digit_stb <= 1'b0;
         key_err   <= 1'b0;
      end else begin
         digits    <= digits_nxt;
         digit_stb <= stb_nxt;
         key_err   <= err_nxt;
      end
   end

   assign bus.sec_unidades = digits.sec_unidades;
   assign bus.sec_dezenas  = digits.sec_dezenas;
   assign bus.minutos      = digits.minutos;
   assign bus.digit_stb    = digit_stb;
   assign bus.key_err      = key_err;
   assign bus.time_nonzero = (digits != '0);

`ifdef KEYPAD_BEEP_EN
   logic        beep;
   logic [15:0] beep_cnt;

   // Beep rises with digit_stb and lasts BEEP_CYCLES; a new accept restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beep     <= 1'b0;
         beep_cnt <= '0;
      end else if (stb_nxt) begin
         beep     <= 1'b1;
         beep_cnt <= BEEP_CYCLES - 16'd1;
      end else if (beep) begin
         if (beep_cnt == '0) begin
            beep <= 1'b0;
         end else begin
            beep_cnt <= beep_cnt - 16'd1;
         end
      end
   end

   assign bus.beep = beep;
`else
   logic beep_cfg_unused;

   assign beep_cfg_unused = |BEEP_CYCLES;
   assign bus.beep        = 1'b0;
`endif

endmodule
